// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential word fetches, buffers responses in a
// small FIFO for the decoder, and handles redirects and misaligned-target halts.
`timescale 1ns/1ps

module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    BUF_DEPTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    output logic                  fetch_err_o
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(BUF_DEPTH - 1);
    localparam logic [OCC_W-1:0]      DEPTH_OCC = OCC_W'(BUF_DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  outstanding;
    logic                  discard;
    logic                  post_rst;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [ADDR_WIDTH-1:0] pc_mem    [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem [BUF_DEPTH];

    logic             running;
    logic             misaligned;
    logic [OCC_W-1:0] occupancy;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_comb begin
        running       = (state == RUN) && !rst_i;
        misaligned    = (redirect_pc_i[1:0] != 2'b00);
        // An in-flight response already owns a buffer slot, so it counts against capacity.
        occupancy     = OCC_W'(count) + OCC_W'(outstanding);
        imem_req_o    = running && !redirect_i && (occupancy < DEPTH_OCC);
        imem_addr_o   = fetch_pc;
        instr_valid_o = running && (count != '0);
        instr_o       = instr_mem[rd_ptr];
        instr_pc_o    = pc_mem[rd_ptr];
        pop           = instr_valid_o && instr_ready_i;
        // The first cycle after reset may still see a response to a pre-reset request.
        push          = running && imem_rvalid_i && !redirect_i && !discard && !post_rst;
        fetch_err_o   = (state == HALT);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        post_rst <= rst_i;
        if (rst_i) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= imem_req_o || (outstanding && !imem_rvalid_i);
            if (imem_rvalid_i) discard <= 1'b0;
            if (imem_req_o) fetch_pc <= fetch_pc + STRIDE;

            case (state)
                RUN: begin
                    if (redirect_i) begin
                        count  <= '0;
                        rd_ptr <= '0;
                        wr_ptr <= '0;
                        if (misaligned) begin
                            state <= HALT;
                        end else begin
                            fetch_pc <= redirect_pc_i;
                            // Only a response still to come after this cycle must be dropped.
                            discard  <= outstanding && !imem_rvalid_i;
                        end
                    end else begin
                        if (push) wr_ptr <= ptr_inc(wr_ptr);
                        if (pop) rd_ptr <= ptr_inc(rd_ptr);
                        case ({push, pop})
                            2'b10:   count <= count + CNT_W'(1);
                            2'b01:   count <= count - CNT_W'(1);
                            default: ;
                        endcase
                    end
                end
                HALT: begin
                    count  <= '0;
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                end
                default: state <= RUN;
            endcase
        end
    end

    // NOTE: buffer storage and the request PC carry no reset; count and pointers gate every read.
    always_ff @(posedge clk_i) begin
        if (imem_req_o) req_pc <= fetch_pc;
        if (push) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a cycle model predicts requests and a scoreboard
// queue holds the instructions expected at the consumer port.
`timescale 1ns/1ps

module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        req, rvalid = 1'b0, redirect = 1'b0, valid, ready = 1'b0, err;
    logic [31:0] addr, rdata = '0, redirect_pc = '0, instr, instr_pc;

    logic        req2, rvalid2 = 1'b0, valid2, err2;
    logic [31:0] addr2, rdata2 = '0, instr2, instr_pc2;

    fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .imem_req_o(req), .imem_addr_o(addr),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .instr_valid_o(valid), .instr_ready_i(ready),
        .instr_o(instr), .instr_pc_o(instr_pc), .fetch_err_o(err)
    );

    fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(DEPTH)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2), .redirect_i(1'b0),
        .redirect_pc_i(32'h0), .instr_valid_o(valid2), .instr_ready_i(1'b1),
        .instr_o(instr2), .instr_pc_o(instr_pc2), .fetch_err_o(err2)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t exp_q[$];
    int     vectors = 0;
    int     miscompares = 0;

    logic [31:0] m_pc = 32'h0, m_rpc = 32'h0;
    bit          m_out = 1'b0, m_halt = 1'b0;
    bit          inject_stale = 1'b0;

    logic        s_req, s_valid, s_err, s_req2, s_valid2;
    logic [31:0] s_addr, s_pc, s_instr, s_addr2, s_pc2;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0004: return 32'h0010_0093;
            default:       return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
        endcase
    endfunction

    // Predicts this cycle's outputs, compares, then advances the model across the clock edge.
    task automatic model_step();
        bit     exp_req, exp_valid;
        entry_t e;
        exp_req   = !rst && !m_halt && !redirect && ((exp_q.size() + int'(m_out)) < DEPTH);
        exp_valid = !rst && !m_halt && (exp_q.size() != 0);
        vectors++;
        if (req !== exp_req) begin
            miscompares++;
            $display("FAIL imem_req at %0t: got %b want %b", $time, req, exp_req);
        end
        if (exp_req) begin
            vectors++;
            if (addr !== m_pc) begin
                miscompares++;
                $display("FAIL imem_addr at %0t: got %h want %h", $time, addr, m_pc);
            end
        end
        vectors++;
        if (valid !== exp_valid) begin
            miscompares++;
            $display("FAIL instr_valid at %0t: got %b want %b", $time, valid, exp_valid);
        end
        vectors++;
        if (err !== m_halt) begin
            miscompares++;
            $display("FAIL fetch_err at %0t: got %b want %b", $time, err, m_halt);
        end

        if (rst) begin
            m_pc   = 32'h0;
            m_out  = 1'b0;
            m_halt = 1'b0;
            exp_q.delete();
        end else begin
            if (exp_valid && ready) begin
                e = exp_q.pop_front();
                vectors++;
                if (instr_pc !== e.pc || instr !== e.instr) begin
                    miscompares++;
                    $display("FAIL transfer at %0t: got pc %h instr %h want pc %h instr %h",
                             $time, instr_pc, instr, e.pc, e.instr);
                end
            end
            if (!m_halt) begin
                if (m_out && !redirect) begin
                    e.pc    = m_rpc;
                    e.instr = mem_word(m_rpc);
                    exp_q.push_back(e);
                end
                if (redirect) begin
                    exp_q.delete();
                    if (redirect_pc[1:0] != 2'b00) m_halt = 1'b1;
                    else m_pc = redirect_pc;
                end
            end
            if (exp_req) begin
                m_rpc = m_pc;
                m_pc  = m_pc + 32'd4;
            end
            m_out = exp_req;
        end
    endtask

    // One clock: sample at negedge, run the model, then answer memory requests after the edge.
    task automatic cycle();
        logic        mreq, mreq2;
        logic [31:0] maddr, maddr2;
        @(negedge clk);
        s_req = req;  s_addr = addr;  s_valid = valid;  s_pc = instr_pc;  s_instr = instr;  s_err = err;
        s_req2 = req2;  s_addr2 = addr2;  s_valid2 = valid2;  s_pc2 = instr_pc2;
        model_step();
        mreq = req;  maddr = addr;  mreq2 = req2;  maddr2 = addr2;
        @(posedge clk);
        #1;
        rvalid       = mreq || inject_stale;
        rdata        = mreq ? mem_word(maddr) : 32'hDEAD_BEEF;
        inject_stale = 1'b0;
        rvalid2      = mreq2;
        rdata2       = mem_word(maddr2);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        ready = 1'b1;
        cycle();
        cycle();
        vectors += 3;
        if (s_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", s_req); end
        if (s_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", s_valid); end
        if (s_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", s_err); end
    endtask

    task automatic test_stream();
        rst   = 1'b0;
        ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (k < 3) begin
                vectors++;
                if (s_req !== 1'b1 || s_addr !== 32'(4 * k)) begin
                    miscompares++;
                    $display("FAIL stream_req%0d: got %b/%h want 1/%h", k, s_req, s_addr, 32'(4 * k));
                end
            end
            vectors++;
            if (k < 2 && s_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL stream_early_valid%0d: got %b want 0", k, s_valid);
            end else if (k >= 2 && (s_valid !== 1'b1 || s_pc !== 32'(4 * (k - 2)))) begin
                miscompares++;
                $display("FAIL stream_out%0d: got %b/%h want 1/%h", k, s_valid, s_pc, 32'(4 * (k - 2)));
            end
            if (k == 2 || k == 3) begin
                vectors++;
                if (s_instr !== ((k == 2) ? 32'h0000_0013 : 32'h0010_0093)) begin
                    miscompares++;
                    $display("FAIL stream_instr%0d: got %h", k, s_instr);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            n += int'(s_req);
        end
        vectors += 2;
        if (n != DEPTH) begin miscompares++; $display("FAIL bp_requests: got %0d want %0d", n, DEPTH); end
        if (s_req !== 1'b0) begin miscompares++; $display("FAIL bp_req_full: got %b want 0", s_req); end
        ready = 1'b1;
        cycle();
        vectors++;
        if (s_valid !== 1'b1 || s_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL bp_first_pop: got %b/%h want 1/00000000", s_valid, s_pc);
        end
        cycle();
        vectors++;
        if (s_req !== 1'b1) begin miscompares++; $display("FAIL bp_resume: got %b want 1", s_req); end
        for (int k = 0; k < 8; k++) cycle();
    endtask

    task automatic test_redirect();
        do_reset();
        ready = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        cycle();
        redirect = 1'b0;
        vectors++;
        if (s_req !== 1'b0) begin miscompares++; $display("FAIL redir_req_same: got %b want 0", s_req); end
        cycle();
        vectors += 2;
        if (s_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush: got %b want 0", s_valid); end
        if (s_req !== 1'b1 || s_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL redir_target: got %b/%h want 1/00000100", s_req, s_addr);
        end
        cycle();
        vectors++;
        if (s_valid !== 1'b0) begin miscompares++; $display("FAIL redir_drop: got %b want 0", s_valid); end
        cycle();
        vectors++;
        if (s_valid !== 1'b1 || s_pc !== 32'h100) begin
            miscompares++;
            $display("FAIL redir_first: got %b/%h want 1/00000100", s_valid, s_pc);
        end
        ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
    endtask

    task automatic test_redirect_transfer();
        ready       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        cycle();
        redirect = 1'b0;
        vectors++;
        if (s_valid !== 1'b1) begin miscompares++; $display("FAIL rt_transfer: got %b want 1", s_valid); end
        cycle();
        vectors++;
        if (s_valid !== 1'b0) begin miscompares++; $display("FAIL rt_flush: got %b want 0", s_valid); end
        ready = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        cycle();
        redirect = 1'b0;
        vectors++;
        if (s_valid !== 1'b1) begin miscompares++; $display("FAIL rt_stalled_valid: got %b want 1", s_valid); end
        cycle();
        vectors++;
        if (s_valid !== 1'b0) begin miscompares++; $display("FAIL rt_stalled_flush: got %b want 0", s_valid); end
        ready = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
    endtask

    task automatic test_misaligned();
        ready       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        cycle();
        redirect = 1'b0;
        for (int k = 0; k < 5; k++) begin
            redirect    = (k == 2);
            redirect_pc = 32'h0000_0400;
            cycle();
            vectors++;
            if (s_err !== 1'b1 || s_req !== 1'b0 || s_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL halt%0d: got err/req/valid %b/%b/%b want 1/0/0", k, s_err, s_req, s_valid);
            end
        end
        redirect = 1'b0;
        rst      = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        vectors++;
        if (s_err !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL halt_exit: got err/req/addr %b/%b/%h want 0/1/00000000", s_err, s_req, s_addr);
        end
        for (int k = 0; k < 4; k++) cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        rst          = 1'b1;
        inject_stale = 1'b1;
        cycle();
        rst   = 1'b0;
        ready = 1'b1;
        cycle();
        vectors++;
        if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL rmid_first: got valid/req/addr %b/%b/%h want 0/1/00000000", s_valid, s_req, s_addr);
        end
        cycle();
        vectors++;
        if (s_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_stale: got %b want 0", s_valid); end
        cycle();
        vectors++;
        if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_instr !== 32'h0000_0013) begin
            miscompares++;
            $display("FAIL rmid_refetch: got %b/%h/%h want 1/00000000/00000013", s_valid, s_pc, s_instr);
        end
        for (int k = 0; k < 4; k++) cycle();
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        want[0] = 32'hFFFF_FFF8;
        want[1] = 32'hFFFF_FFFC;
        want[2] = 32'h0000_0000;
        rst = 1'b1;
        cycle();
        rst   = 1'b0;
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            vectors++;
            if (s_req2 !== 1'b1 || s_addr2 !== want[k]) begin
                miscompares++;
                $display("FAIL wrap_req%0d: got %b/%h want 1/%h", k, s_req2, s_addr2, want[k]);
            end
        end
        vectors++;
        if (s_valid2 !== 1'b1 || s_pc2 !== 32'hFFFF_FFF8) begin
            miscompares++;
            $display("FAIL wrap_out: got %b/%h want 1/fffffff8", s_valid2, s_pc2);
        end
        for (int k = 0; k < 3; k++) cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_transfer();
        test_misaligned();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
